regfile_operand_fetch: RTL and testbench

//  Operand-fetch stage sitting between decode and execute. Drives the read ports of the 2r1w

---
 rtl/regfile_operand_fetch.sv | 157 +++++++++++++++
 tb/tb_regfile_operand_fetch.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_fetch.sv
// rtl/regfile_operand_fetch.sv - operand fetch stage between decode and execute
//
// Purpose: issues register-file BRAM reads for an accepted op, merges the
// 1-cycle BRAM read data with writeback forwarding, and holds the operands and
// payload stable while execute stalls.
//
// Build option: define ZERO_REG_EN to make register index 0 read as zero.
// Register 0 is then never forwarded and never updated in the hold registers.
// The BRAM is still read for index 0.
//
// Ports:
//   clk, rst_n                clock, synchronous active-low reset
//   flush                     kill the in-flight/held op
//   in_valid/in_ready         decode handshake; in_rs1, in_rs2, in_payload
//   rf_rd_en_a/b, rf_rd_addr_a/b, rf_rd_data_a/b
//                             BRAM read ports (data valid one cycle after enable)
//   wb_en, wb_addr, wb_data   writeback snoop
//   out_valid/out_ready       execute handshake; out_rs1_data, out_rs2_data, out_payload

module regfile_operand_fetch #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int PAYLOAD_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_WIDTH-1:0]    in_rs1,
    input  logic [ADDR_WIDTH-1:0]    in_rs2,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic                     rf_rd_en_a,
    output logic                     rf_rd_en_b,
    output logic [ADDR_WIDTH-1:0]    rf_rd_addr_a,
    output logic [ADDR_WIDTH-1:0]    rf_rd_addr_b,
    input  logic [DATA_WIDTH-1:0]    rf_rd_data_a,
    input  logic [DATA_WIDTH-1:0]    rf_rd_data_b,
    input  logic                     wb_en,
    input  logic [ADDR_WIDTH-1:0]    wb_addr,
    input  logic [DATA_WIDTH-1:0]    wb_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_rs1_data,
    output logic [DATA_WIDTH-1:0]    out_rs2_data,
    output logic [PAYLOAD_WIDTH-1:0] out_payload
);

`ifdef ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic                     out_valid_q, out_valid_d;
    logic                     fresh_q, fresh_d;
    logic                     fwd1_q, fwd1_d;
    logic                     fwd2_q, fwd2_d;
    logic [DATA_WIDTH-1:0]    fwd1_data_q, fwd1_data_d;
    logic [DATA_WIDTH-1:0]    fwd2_data_q, fwd2_data_d;
    logic [DATA_WIDTH-1:0]    hold1_q, hold1_d;
    logic [DATA_WIDTH-1:0]    hold2_q, hold2_d;
    logic [ADDR_WIDTH-1:0]    rs1_q, rs1_d;
    logic [ADDR_WIDTH-1:0]    rs2_q, rs2_d;
    logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;

    logic                     accept;
    logic                     zero1_in, zero2_in, zero1_held, zero2_held;
    logic                     hit1_in, hit2_in, hit1_held, hit2_held;
    logic [DATA_WIDTH-1:0]    op1, op2;

    always_comb begin
        // Gated by rst_n so no BRAM read is issued while reset is asserted.
        in_ready     = rst_n & ~flush & (~out_valid_q | out_ready);
        accept       = in_valid & in_ready;
        rf_rd_en_a   = accept;
        rf_rd_en_b   = accept;
        rf_rd_addr_a = in_rs1;
        rf_rd_addr_b = in_rs2;

        zero1_in   = ZERO_EN & (in_rs1 == '0);
        zero2_in   = ZERO_EN & (in_rs2 == '0);
        zero1_held = ZERO_EN & (rs1_q == '0);
        zero2_held = ZERO_EN & (rs2_q == '0);

        // A write in the accept cycle is not visible in the BRAM read data
        // (no read bypass), so it is captured here and wins in the fresh cycle.
        hit1_in   = wb_en & (wb_addr == in_rs1) & ~zero1_in;
        hit2_in   = wb_en & (wb_addr == in_rs2) & ~zero2_in;
        hit1_held = wb_en & (wb_addr == rs1_q) & ~zero1_held;
        hit2_held = wb_en & (wb_addr == rs2_q) & ~zero2_held;

        // Fresh cycle: BRAM data (or accept-cycle forward); later: hold regs.
        op1 = zero1_held ? '0 : (fresh_q ? (fwd1_q ? fwd1_data_q : rf_rd_data_a) : hold1_q);
        op2 = zero2_held ? '0 : (fresh_q ? (fwd2_q ? fwd2_data_q : rf_rd_data_b) : hold2_q);

        out_valid    = out_valid_q;
        out_rs1_data = op1;
        out_rs2_data = op2;
        out_payload  = payload_q;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        if (out_valid_q & out_ready) out_valid_d = 1'b0;
        if (accept)                  out_valid_d = 1'b1;
        if (flush)                   out_valid_d = 1'b0;

        // accept is already low during flush, so this also clears on flush.
        fresh_d     = accept;
        fwd1_d      = accept & hit1_in;
        fwd2_d      = accept & hit2_in;
        fwd1_data_d = accept ? wb_data : fwd1_data_q;
        fwd2_data_d = accept ? wb_data : fwd2_data_q;
        rs1_d       = accept ? in_rs1 : rs1_q;
        rs2_d       = accept ? in_rs2 : rs2_q;
        payload_d   = accept ? in_payload : payload_q;

        // While an op is presented, keep the current operand and fold in any
        // writeback to its source register; it becomes visible next cycle.
        hold1_d = hold1_q;
        hold2_d = hold2_q;
        if (out_valid_q) begin
            hold1_d = hit1_held ? wb_data : op1;
            hold2_d = hit2_held ? wb_data : op2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            fresh_q     <= 1'b0;
            fwd1_q      <= 1'b0;
            fwd2_q      <= 1'b0;
            fwd1_data_q <= '0;
            fwd2_data_q <= '0;
            hold1_q     <= '0;
            hold2_q     <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            payload_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            fresh_q     <= fresh_d;
            fwd1_q      <= fwd1_d;
            fwd2_q      <= fwd2_d;
            fwd1_data_q <= fwd1_data_d;
            fwd2_data_q <= fwd2_data_d;
            hold1_q     <= hold1_d;
            hold2_q     <= hold2_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            payload_q   <= payload_d;
        end
    end

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// tb/tb_regfile_operand_fetch.sv - self-checking bench for regfile_operand_fetch

module tb_regfile_operand_fetch;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int PW = 64;

`ifdef ZERO_REG_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_rs1 = '0;
    logic [AW-1:0] in_rs2 = '0;
    logic [PW-1:0] in_payload = '0;
    logic          rf_rd_en_a, rf_rd_en_b;
    logic [AW-1:0] rf_rd_addr_a, rf_rd_addr_b;
    logic [DW-1:0] rf_rd_data_a = '0;
    logic [DW-1:0] rf_rd_data_b = '0;
    logic          wb_en = 1'b0;
    logic [AW-1:0] wb_addr = '0;
    logic [DW-1:0] wb_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_rs1_data, out_rs2_data;
    logic [PW-1:0] out_payload;

    always #5 clk = ~clk;

    regfile_operand_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PAYLOAD_WIDTH(PW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_payload(in_payload),
        .rf_rd_en_a(rf_rd_en_a), .rf_rd_en_b(rf_rd_en_b),
        .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
        .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_payload(out_payload)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int xfers    = 0;
    bit started  = 1'b0;

    // 2r1w BRAM, read-before-write, 1-cycle latency.
    logic [DW-1:0] bram [32];
    // Architectural register values: the reference for every operand.
    logic [DW-1:0] arch [32];

    // Op currently presented to execute, per the handshake rules.
    logic          m_valid = 1'b0;
    logic [AW-1:0] m_rs1 = '0;
    logic [AW-1:0] m_rs2 = '0;
    logic [PW-1:0] m_pl = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_op(input logic [AW-1:0] rs);
        if (ZERO_EN && rs == '0) return '0;
        return arch[rs];
    endfunction

    always @(posedge clk) begin
        if (rf_rd_en_a) rf_rd_data_a <= bram[rf_rd_addr_a];
        if (rf_rd_en_b) rf_rd_data_b <= bram[rf_rd_addr_b];
        if (wb_en) bram[wb_addr] <= wb_data;
    end

    // Reference model: operands seen in a cycle equal the architectural value
    // of the source register including all writes of earlier cycles.
    always @(posedge clk) begin
        started <= 1'b1;
        if (wb_en) arch[wb_addr] <= wb_data;
        if (!rst_n) begin
            m_valid <= 1'b0;
        end else if (flush) begin
            m_valid <= 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
            m_valid <= 1'b1;
            m_rs1   <= in_rs1;
            m_rs2   <= in_rs2;
            m_pl    <= in_payload;
        end else if (out_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic exp_ir;
            exp_ir = rst_n && !flush && (!m_valid || out_ready);
            check("in_ready", 64'(in_ready), 64'(exp_ir));
            check("rf_rd_en_a", 64'(rf_rd_en_a), 64'(in_valid && exp_ir));
            check("rf_rd_en_b", 64'(rf_rd_en_b), 64'(in_valid && exp_ir));
            check("rf_rd_addr_a", 64'(rf_rd_addr_a), 64'(in_rs1));
            check("rf_rd_addr_b", 64'(rf_rd_addr_b), 64'(in_rs2));
            check("out_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                check("out_rs1_data", 64'(out_rs1_data), 64'(exp_op(m_rs1)));
                check("out_rs2_data", 64'(out_rs2_data), 64'(exp_op(m_rs2)));
                check("out_payload", out_payload, m_pl);
            end
            if (out_valid && out_ready && !flush) xfers++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input int r1, input int r2, input logic [PW-1:0] pl);
        in_valid   = v;
        in_rs1     = AW'(r1);
        in_rs2     = AW'(r2);
        in_payload = pl;
    endtask

    task automatic set_wb(input logic en, input int a, input logic [DW-1:0] d);
        wb_en   = en;
        wb_addr = AW'(a);
        wb_data = d;
    endtask

    initial begin
        int x0;
        for (int i = 0; i < 32; i++) begin
            bram[i] = $urandom;
            arch[i] = bram[i];
        end
        bram[5] = 32'h0000_1234; arch[5] = 32'h0000_1234;
        bram[0] = 32'h0000_0055; arch[0] = 32'h0000_0055;

        // Reset with a pending op: no BRAM read may be issued.
        rst_n = 1'b0;
        set_op(1'b1, 1, 2, 64'h1);
        tick(); tick();
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst out_rs1", 64'(out_rs1_data), 64'd0);
        check("rst out_rs2", 64'(out_rs2_data), 64'd0);
        check("rst out_payload", out_payload, 64'd0);
        check("rst rf_rd_en_a", 64'(rf_rd_en_a), 64'd0);
        rst_n = 1'b1;
        set_op(1'b0, 0, 0, 64'h0);
        #1;
        check("post-rst in_ready", 64'(in_ready), 64'd1);

        // Plain read of r3/r4, then stall with writeback to r4.
        set_wb(1'b1, 3, 32'h11); tick();
        set_wb(1'b1, 4, 32'h22); tick();
        set_wb(1'b0, 0, 0);
        out_ready = 1'b0;
        set_op(1'b1, 3, 4, 64'hDEAD_BEEF_0000_0001);
        tick();
        set_op(1'b1, 6, 7, 64'hDEAD_BEEF_0000_0002);
        check("plain out_valid", 64'(out_valid), 64'd1);
        check("plain rs1", 64'(out_rs1_data), 64'h11);
        check("plain rs2", 64'(out_rs2_data), 64'h22);
        tick();
        set_wb(1'b1, 4, 32'h99);
        check("stall2 rs2 old", 64'(out_rs2_data), 64'h22);
        tick();
        set_wb(1'b0, 0, 0);
        check("stall3 rs2 fwd", 64'(out_rs2_data), 64'h99);
        check("stall3 payload", out_payload, 64'hDEAD_BEEF_0000_0001);
        out_ready = 1'b1;
        tick();

        // Accept-cycle forward over a stale BRAM value.
        set_op(1'b1, 5, 6, 64'h3);
        set_wb(1'b1, 5, 32'hAB);
        tick();
        set_wb(1'b0, 0, 0);
        set_op(1'b0, 0, 0, 64'h0);
        check("accept fwd rs1", 64'(out_rs1_data), 64'hAB);
        tick(); tick();

        // Full throughput: 4 back-to-back ops.
        x0 = xfers;
        for (int i = 0; i < 4; i++) begin
            set_op(1'b1, i + 8, i + 9, 64'(i + 100));
            tick();
        end
        set_op(1'b0, 0, 0, 64'h0);
        tick();
        check("throughput xfers", 64'(xfers - x0), 64'd4);

        // Flush a stalled op.
        out_ready = 1'b0;
        set_op(1'b1, 1, 2, 64'h77);
        tick();
        flush = 1'b1;
        set_op(1'b1, 3, 4, 64'h78);
        tick();
        flush = 1'b0;
        set_op(1'b0, 0, 0, 64'h0);
        check("flush out_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        tick();

        // Register 0 with a concurrent write.
        set_op(1'b1, 0, 0, 64'h5);
        set_wb(1'b1, 0, 32'h77);
        tick();
        set_wb(1'b0, 0, 0);
        set_op(1'b1, 0, 3, 64'h6);
        check("r0 fwd rs1", 64'(out_rs1_data), ZERO_EN ? 64'd0 : 64'h77);
        check("r0 fwd rs2", 64'(out_rs2_data), ZERO_EN ? 64'd0 : 64'h77);
        tick();
        set_op(1'b0, 0, 0, 64'h0);
        check("r0 read rs1", 64'(out_rs1_data), ZERO_EN ? 64'd0 : 64'h77);
        tick();

        // Randomized traffic with collisions on a small register window.
        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 399) != 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            in_rs1     = AW'($urandom_range(0, 7));
            in_rs2     = AW'($urandom_range(0, 7));
            in_payload = {$urandom, $urandom};
            out_ready  = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 19) == 0);
            wb_en      = $urandom_range(0, 1) == 1;
            wb_addr    = AW'($urandom_range(0, 7));
            wb_data    = $urandom;
            tick();
        end
        rst_n = 1'b1;
        flush = 1'b0;

        // Reset while stalled discards the held op.
        out_ready = 1'b0;
        set_wb(1'b0, 0, 0);
        set_op(1'b1, 2, 3, 64'h9);
        tick();
        set_op(1'b0, 0, 0, 64'h0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid-stall rst out_valid", 64'(out_valid), 64'd0);
        check("mid-stall rst payload", out_payload, 64'd0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
